// File: rtl/sram_arb_pkg.sv
// Shared types and idle-encoding constants for the single-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2
    } grant_e;

    // Macro controls are active-low, so "do nothing" is all ones.
    localparam logic SRAM_CEB_IDLE      = 1'b1;
    localparam logic SRAM_WEB_IDLE      = 1'b1;
    localparam logic SRAM_BWEB_IDLE_BIT = 1'b1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin arbiter; one pointer flop (0 = write preferred).
module sram_rr_arb2
    import sram_arb_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   en_i,
    input  logic   rd_valid_i,
    input  logic   wr_valid_i,
    output grant_e grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = G_NONE;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (rd_valid_i && wr_valid_i) begin
                grant_o = ptr_q ? G_RD : G_WR;
            end else if (wr_valid_i) begin
                grant_o = G_WR;
            end else if (rd_valid_i) begin
                grant_o = G_RD;
            end
        end
        // Any grant hands priority to the other side.
        if (grant_o == G_WR) begin
            ptr_d = 1'b1;
        end else if (grant_o == G_RD) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_1p_arbiter.sv
// Shares one single-port bit-write SRAM macro between a read and a write requester,
// with optional zero-fill after reset and a read-data hold register.
module sram_1p_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 6,
    parameter int DEPTH          = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [ADDR_W-1:0] rreq_addr,
    output logic              rresp_valid,
    output logic [DATA_W-1:0] rresp_data,
    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  logic [DATA_W-1:0] wreq_data,
    input  logic [DATA_W-1:0] wreq_mask,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic              init_done
);

    localparam state_e            RESET_STATE   = (CLEAR_ON_RESET != 0) ? INIT : RUN;
    localparam logic              INIT_DONE_RST = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                rvalid_q;
    logic [DATA_W-1:0]   hold_q;
    grant_e              grant;
    logic                run_en;

    // Gating with reset_n keeps the macro idle while reset is held low.
    assign run_en = reset_n && (state_q == RUN);

    sram_rr_arb2 u_arb (
        .clock      (clock),
        .reset_n    (reset_n),
        .en_i       (run_en),
        .rd_valid_i (rreq_valid),
        .wr_valid_i (wreq_valid),
        .grant_o    (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        sram_ceb    = SRAM_CEB_IDLE;
        sram_web    = SRAM_WEB_IDLE;
        sram_bweb   = {DATA_W{SRAM_BWEB_IDLE_BIT}};
        sram_a      = '0;
        sram_d      = '0;
        rreq_ready  = 1'b0;
        wreq_ready  = 1'b0;
        if (reset_n) begin
            if (state_q == INIT) begin
                sram_ceb  = 1'b0;
                sram_web  = 1'b0;
                sram_bweb = '0;
                sram_a    = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end else begin
                case (grant)
                    G_WR: begin
                        wreq_ready = 1'b1;
                        sram_ceb   = 1'b0;
                        sram_web   = 1'b0;
                        sram_bweb  = ~wreq_mask;
                        sram_a     = wreq_addr;
                        sram_d     = wreq_data;
                    end
                    G_RD: begin
                        rreq_ready = 1'b1;
                        sram_ceb   = 1'b0;
                        sram_a     = rreq_addr;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            init_done_q <= INIT_DONE_RST;
            rvalid_q    <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rvalid_q    <= (grant == G_RD);
            if (rvalid_q) begin
                hold_q <= sram_q;
            end
        end
    end

    // Q is only defined in the response cycle; afterwards the captured copy is shown.
    assign rresp_valid = rvalid_q;
    assign rresp_data  = rvalid_q ? sram_q : hold_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Directed bench for sram_1p_arbiter with a behavioural bit-write SRAM macro.
module tb_sram_1p_arbiter;

    localparam int DW = 128;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rreq_valid = 1'b0;
    logic          rreq_ready;
    logic [AW-1:0] rreq_addr = '0;
    logic          rresp_valid;
    logic [DW-1:0] rresp_data;
    logic          wreq_valid = 1'b0;
    logic          wreq_ready;
    logic [AW-1:0] wreq_addr = '0;
    logic [DW-1:0] wreq_data = '0;
    logic [DW-1:0] wreq_mask = '0;
    logic          sram_ceb;
    logic          sram_web;
    logic [DW-1:0] sram_bweb;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;
    logic          init_done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] LO64 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [DW-1:0] HI64 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    sram_1p_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
        .rresp_valid(rresp_valid), .rresp_data(rresp_data),
        .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
        .wreq_data(wreq_data), .wreq_mask(wreq_mask),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .init_done(init_done)
    );

    always #5 clock = ~clock;

    // Macro model: garbage preloaded, bit-write at the edge, Q random outside response cycles.
    logic [DW-1:0] mem [64];
    bit            preloaded = 1'b0;
    always @(posedge clock) begin
        if (!preloaded) begin
            for (int k = 0; k < 64; k++) mem[k] <= {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            preloaded <= 1'b1;
        end else if (!sram_ceb && !sram_web) begin
            mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
        end
        if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
        else                       sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock); #1;
        n_checks++;
        if ({sram_ceb, sram_web, rreq_ready, wreq_ready, rresp_valid, init_done} !== 6'b110000
            || sram_bweb !== ONES || sram_a !== '0 || sram_d !== '0 || rresp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ceb=%b web=%b rr=%b wr=%b rv=%b idn=%b a=%0d, required 1 1 0 0 0 0 a=0 idle",
                     sram_ceb, sram_web, rreq_ready, wreq_ready, rresp_valid, init_done, sram_a);
        end
        @(negedge clock);
        reset_n = 1'b1; rreq_valid = 1'b1; wreq_valid = 1'b1; wreq_mask = ONES; wreq_data = ONES;
        for (int i = 0; i < 64; i++) begin
            #1;
            n_checks++;
            if ({sram_ceb, sram_web, rreq_ready, wreq_ready, init_done} !== 5'b00000
                || sram_bweb !== '0 || sram_d !== '0 || sram_a !== AW'(i)) begin
                n_fail++;
                $display("FAIL init_sweep[%0d]: ceb=%b web=%b rr=%b wr=%b idn=%b a=%0d bweb=%h, required all 0 a=%0d",
                         i, sram_ceb, sram_web, rreq_ready, wreq_ready, init_done, sram_a, sram_bweb, i);
            end
            if (i == 63) begin rreq_valid = 1'b0; wreq_valid = 1'b0; end
            @(negedge clock);
        end
        #1;
        n_checks++;
        if (init_done !== 1'b1 || sram_ceb !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_65: init_done=%b ceb=%b, required 1 1", init_done, sram_ceb);
        end
        $display("test_reset: 64-cycle clear sweep done");
    endtask

    task automatic test_read_after_init();
        @(negedge clock);
        rreq_valid = 1'b1; rreq_addr = 6'd5; #1;
        n_checks++;
        if ({rreq_ready, wreq_ready, sram_ceb, sram_web} !== 4'b1001 || sram_a !== 6'd5 || sram_bweb !== ONES) begin
            n_fail++;
            $display("FAIL read_grant: rr=%b wr=%b ceb=%b web=%b a=%0d, required 1 0 0 1 a=5",
                     rreq_ready, wreq_ready, sram_ceb, sram_web, sram_a);
        end
        @(negedge clock);
        rreq_valid = 1'b0; #1;
        n_checks++;
        if (rresp_valid !== 1'b1 || rresp_data !== '0) begin
            n_fail++;
            $display("FAIL read_cleared: rv=%b data=%h, required 1 0", rresp_valid, rresp_data);
        end
        $display("test_read_after_init: read addr 5 -> %h", rresp_data);
    endtask

    task automatic test_masked_write();
        @(negedge clock);
        wreq_valid = 1'b1; wreq_addr = 6'd3; wreq_data = ONES; wreq_mask = LO64; #1;
        n_checks++;
        if ({wreq_ready, rreq_ready, sram_ceb, sram_web} !== 4'b1000 || sram_bweb !== HI64
            || sram_d !== ONES || sram_a !== 6'd3) begin
            n_fail++;
            $display("FAIL write_lo: wr=%b ceb=%b web=%b bweb=%h a=%0d, required 1 0 0 bweb=%h a=3",
                     wreq_ready, sram_ceb, sram_web, sram_bweb, sram_a, HI64);
        end
        @(negedge clock);
        wreq_data = '0; wreq_mask = HI64; #1;
        n_checks++;
        if (wreq_ready !== 1'b1 || sram_bweb !== LO64 || sram_d !== '0) begin
            n_fail++;
            $display("FAIL write_hi: wr=%b bweb=%h d=%h, required 1 %h 0", wreq_ready, sram_bweb, sram_d, LO64);
        end
        @(negedge clock);
        wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 6'd3;
        @(negedge clock);
        rreq_valid = 1'b0; #1;
        n_checks++;
        if (rresp_valid !== 1'b1 || rresp_data !== LO64) begin
            n_fail++;
            $display("FAIL masked_read: rv=%b data=%h, required 1 %h", rresp_valid, rresp_data, LO64);
        end
        $display("test_masked_write: addr 3 -> %h", rresp_data);
    endtask

    task automatic test_both_valid();
        logic [2:0] exp [4];
        exp[0] = 3'b100; exp[1] = 3'b010; exp[2] = 3'b101; exp[3] = 3'b010;
        @(negedge clock);
        wreq_valid = 1'b1; wreq_addr = 6'd10; wreq_data = 128'hA5A5; wreq_mask = ONES;
        rreq_valid = 1'b1; rreq_addr = 6'd3;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if ({wreq_ready, rreq_ready, rresp_valid} !== exp[c]
                || (rresp_valid === 1'b1 && rresp_data !== LO64)) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: wr/rr/rv=%b data=%h, required %b", c,
                         {wreq_ready, rreq_ready, rresp_valid}, rresp_data, exp[c]);
            end
            @(negedge clock);
        end
        wreq_valid = 1'b0; rreq_valid = 1'b0; #1;
        n_checks++;
        if (rresp_valid !== 1'b1 || rresp_data !== LO64 || wreq_ready !== 1'b0 || rreq_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_last_resp: rv=%b data=%h, required 1 %h", rresp_valid, rresp_data, LO64);
        end
        $display("test_both_valid: W,R,W,R grant sequence");
    endtask

    task automatic test_hold();
        @(negedge clock);
        wreq_valid = 1'b1; wreq_addr = 6'd7; wreq_data = 128'h1234; wreq_mask = ONES;
        @(negedge clock);
        wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 6'd7;
        @(negedge clock);
        rreq_valid = 1'b0; #1;
        n_checks++;
        if (rresp_valid !== 1'b1 || rresp_data !== 128'h1234) begin
            n_fail++;
            $display("FAIL raw_read: rv=%b data=%h, required 1 1234", rresp_valid, rresp_data);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock); #1;
            n_checks++;
            if (rresp_valid !== 1'b0 || rresp_data !== 128'h1234) begin
                n_fail++;
                $display("FAIL hold%0d: rv=%b data=%h, required 0 1234", c, rresp_valid, rresp_data);
            end
        end
        $display("test_hold: data held at %h", rresp_data);
    endtask

    task automatic test_reset_after_read();
        @(negedge clock);
        rreq_valid = 1'b1; rreq_addr = 6'd7;
        @(negedge clock);
        rreq_valid = 1'b0; reset_n = 1'b0; #1;
        n_checks++;
        if (rresp_valid !== 1'b0 || rresp_data !== '0 || sram_ceb !== 1'b1 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: rv=%b data=%h ceb=%b idn=%b, required 0 0 1 0",
                     rresp_valid, rresp_data, sram_ceb, init_done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock); #1;
            n_checks++;
            if (rresp_valid !== 1'b0 || rresp_data !== '0) begin
                n_fail++;
                $display("FAIL no_resp%0d: rv=%b data=%h, required 0 0", c, rresp_valid, rresp_data);
            end
        end
        $display("test_reset_after_read: response dropped");
    endtask

    task automatic test_reset_mid_init();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            #1;
            n_checks++;
            if (sram_ceb !== 1'b0 || sram_a !== AW'(i)) begin
                n_fail++;
                $display("FAIL pre_pulse[%0d]: ceb=%b a=%0d, required 0 a=%0d", i, sram_ceb, sram_a, i);
            end
            if (i < 20) @(negedge clock);
        end
        reset_n = 1'b0; #1;
        n_checks++;
        if (sram_ceb !== 1'b1 || sram_web !== 1'b1 || sram_a !== '0 || sram_bweb !== ONES) begin
            n_fail++;
            $display("FAIL pulse_idle: ceb=%b web=%b a=%0d, required 1 1 0", sram_ceb, sram_web, sram_a);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            n_checks++;
            if ({sram_ceb, sram_web, init_done} !== 3'b000 || sram_a !== AW'(i) || sram_bweb !== '0) begin
                n_fail++;
                $display("FAIL restart[%0d]: ceb=%b web=%b idn=%b a=%0d, required 0 0 0 a=%0d",
                         i, sram_ceb, sram_web, init_done, sram_a, i);
            end
            @(negedge clock);
        end
        #1;
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_done: init_done=%b, required 1", init_done);
        end
        $display("test_reset_mid_init: INIT restarted from 0");
    endtask

    initial begin
        test_reset();
        test_read_after_init();
        test_masked_write();
        test_both_valid();
        test_hold();
        test_reset_after_read();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1p_arbiter.md
Name: sram_1p_arbiter

Overview:
- Controller that shares one single-port, bit-write-enable SRAM macro (active-low CEB/WEB/BWEB, 1-cycle read latency, Q undefined outside the read-response cycle) between one read requester and one write requester.
- Provides an optional zero-fill of the whole array after reset and holds read data stable after the response cycle.
- Sits between cache/meta-array logic and the macro instance.

Parameters:
- DATA_W, 128, data and bit-mask width.
- ADDR_W, 6, address width.
- DEPTH, 64, number of words; DEPTH <= 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = zero-fill every word after reset before accepting requests.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rreq_valid  in  1  read request.
- rreq_ready  out  1  read request accepted this cycle.
- rreq_addr  in  ADDR_W  read address.
- rresp_valid  out  1  read data valid; one-cycle pulse, no back-pressure.
- rresp_data  out  DATA_W  read data.
- wreq_valid  in  1  write request.
- wreq_ready  out  1  write request accepted this cycle.
- wreq_addr  in  ADDR_W  write address.
- wreq_data  in  DATA_W  write data.
- wreq_mask  in  DATA_W  active-high per-bit write enable.
- sram_ceb  out  1  macro chip enable, active-low.
- sram_web  out  1  macro write enable, active-low.
- sram_bweb  out  DATA_W  macro bit-write enable, active-low.
- sram_a  out  ADDR_W  macro address.
- sram_d  out  DATA_W  macro write data.
- sram_q  in  DATA_W  macro read data.
- init_done  out  1  high once the array is usable.

Behaviour:
- FSM states: INIT, RUN. Reset state is INIT if CLEAR_ON_RESET=1, else RUN.
- Reset values of registered outputs: rresp_valid=0, rresp_data hold register=0, init_done=CLEAR_ON_RESET?0:1, clear counter=0, rr pointer=0 (write preferred).
- Combinational outputs during reset: rreq_ready=0, wreq_ready=0; SRAM idle encoding (below).
- Idle SRAM encoding: ceb=1, web=1, bweb=all 1, a=0, d=0. Driven whenever no access is granted.
- All sram_* outputs are combinational from the grant and the registered state; the macro samples them at the next rising edge.
- INIT:
  - Each cycle issue a write: ceb=0, web=0, bweb=all 0, a=counter, d=0; counter increments.
  - rreq_ready=0 and wreq_ready=0 throughout.
  - When counter==DEPTH-1 is issued, go to RUN next cycle; init_done rises that same next cycle.
  - INIT lasts exactly DEPTH cycles.
- RUN, grant rules (at most one access per cycle):
  - Only wreq_valid: grant write.
  - Only rreq_valid: grant read.
  - Both valid: grant the side the rr pointer selects. After any grant, the pointer selects the other side.
  - ready is asserted only to the granted side, in the same cycle. Requesters hold valid and payload until ready; valid must not depend on ready.
- Write grant: ceb=0, web=0, a=wreq_addr, d=wreq_data, bweb=~wreq_mask. A mask of all 0 still performs the access and changes no bits.
- Read grant: ceb=0, web=1, bweb=all 1, a=rreq_addr.
  - rresp_valid=1 in the next cycle, with rresp_data=sram_q (combinational pass-through).
  - sram_q is captured into the hold register at the end of that cycle.
  - In every later cycle rresp_data = hold register, stable until the next response.
- Read-after-write to the same address on consecutive cycles returns the new data. No bypass is needed; the macro writes at the edge.
- Back-to-back reads: one per cycle, full throughput, responses in request order.
- Reset asserted mid-operation:
  - Immediately: SRAM idle, readies 0, rresp_valid 0.
  - Any in-flight read response is dropped; the hold register clears to 0.
  - The FSM restarts INIT from address 0.

Decomposition:
- Package sram_arb_pkg:
  - state enum {INIT, RUN};
  - grant enum {G_NONE, G_RD, G_WR};
  - idle-encoding constants for ceb, web and bweb.
- One natural sub-module: sram_rr_arb2, a two-requester round-robin arbiter with one pointer flop. It outputs the grant enum from two valids and the pointer.
- The top level holds the FSM, clear counter, response pipeline and hold register.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 -> 64 cycles of ceb=0, web=0, bweb=0, d=0, a=0..63, readies 0; init_done=1 in cycle 65; then read addr 5 -> rresp_data=0.
- Write addr 3, data all-ones, mask low 64 bits; then write addr 3, data 0, mask high 64 bits; then read addr 3 -> rresp_data = upper 64 bits 0, lower 64 bits all ones.
- rreq_valid and wreq_valid held high for 4 cycles from reset (pointer=write) -> grants W,R,W,R; rresp_valid pulses the cycle after each R grant.
- Read addr 7 (holding 0x1234) then 5 idle cycles, macro model randomises sram_q -> rresp_data stays 0x1234 in all 5 cycles.
- reset_n pulsed low during INIT at counter=20 -> immediately ceb=1; after release INIT restarts at a=0 and runs the full 64 cycles.
- Read granted, reset_n asserted the next cycle -> rresp_valid=0, rresp_data=0; no response after release.
